// File: rtl/ioc_bus_master.sv
// IOC bus initiator: decodes SPI command bytes into fetch/load accesses on the register modules.
// Optional `IOC_BUS_MASTER_BURST_EN: auto-incrementing follow-on accesses within one frame.
module ioc_bus_master #(
    parameter int NUM_MODULES = 4
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_frame_active,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_rx_valid,
    output logic [7:0]               o_tx_byte,
    output logic                     o_tx_valid,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    output logic [NUM_MODULES-1:0]   o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd,
    input  logic [8*NUM_MODULES-1:0] i_data_in
);

    localparam int MOD_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        FETCH,
        CAPTURE,
        LOAD,
        DONE,
        BURST_WAIT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [MOD_W-1:0]   mod_idx;
    logic               mod_valid;
    logic               frame_stale;
    logic               accept_op;
    logic               accept_data;
    logic [3:0]         cs_onehot;
    logic [31:0]        data_pad;
    logic [7:0]         data_sel;
`ifdef IOC_BUS_MASTER_BURST_EN
    logic               is_read;
    logic               accept_burst;
`endif

    assign mod_valid = (32'(mod_idx) < NUM_MODULES);
    assign cs_onehot = 4'b0001 << mod_idx;
    assign data_pad  = 32'(i_data_in);
    assign data_sel  = data_pad[{mod_idx, 3'b000} +: 8];

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        o_cs         = '0;
        o_fetch_cmd  = 1'b0;
        o_load_cmd   = 1'b0;
        accept_op    = 1'b0;
        accept_data  = 1'b0;
`ifdef IOC_BUS_MASTER_BURST_EN
        accept_burst = 1'b0;
`endif
        case (state)
            IDLE: begin
                // frame_stale blocks mid-frame bytes after a reset from being taken as an opcode
                if (i_frame_active && !frame_stale && i_rx_valid) begin
                    accept_op  = 1'b1;
                    next_state = i_rx_byte[7] ? FETCH : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!i_frame_active)
                    next_state = IDLE;
                else if (i_rx_valid) begin
                    accept_data = mod_valid;
                    next_state  = mod_valid ? LOAD : DONE;
                end
            end
            FETCH: begin
                o_cs        = mod_valid ? cs_onehot[NUM_MODULES-1:0] : '0;
                o_fetch_cmd = mod_valid;
                next_state  = CAPTURE;
            end
            CAPTURE: begin
                o_cs = mod_valid ? cs_onehot[NUM_MODULES-1:0] : '0;
`ifdef IOC_BUS_MASTER_BURST_EN
                next_state = i_frame_active ? BURST_WAIT : IDLE;
`else
                next_state = i_frame_active ? DONE : IDLE;
`endif
            end
            LOAD: begin
                o_cs       = mod_valid ? cs_onehot[NUM_MODULES-1:0] : '0;
                o_load_cmd = mod_valid;
`ifdef IOC_BUS_MASTER_BURST_EN
                next_state = i_frame_active ? BURST_WAIT : IDLE;
`else
                next_state = i_frame_active ? DONE : IDLE;
`endif
            end
            DONE: begin
                if (!i_frame_active)
                    next_state = IDLE;
            end
`ifdef IOC_BUS_MASTER_BURST_EN
            BURST_WAIT: begin
                // invalid-module burst writes are swallowed here but still advance the address
                if (!i_frame_active)
                    next_state = IDLE;
                else if (i_rx_valid) begin
                    accept_burst = 1'b1;
                    accept_data  = !is_read && mod_valid;
                    if (is_read)
                        next_state = FETCH;
                    else
                        next_state = mod_valid ? LOAD : BURST_WAIT;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b) begin
            o_ioc       <= '0;
            o_data_out  <= '0;
            o_tx_byte   <= '0;
            o_tx_valid  <= 1'b0;
            mod_idx     <= '0;
            frame_stale <= 1'b1;
`ifdef IOC_BUS_MASTER_BURST_EN
            is_read     <= 1'b0;
`endif
        end else begin
            o_tx_valid <= 1'b0;
            if (!i_frame_active)
                frame_stale <= 1'b0;
            if (accept_op) begin
                o_ioc   <= i_rx_byte[4:0];
                mod_idx <= i_rx_byte[6:5];
`ifdef IOC_BUS_MASTER_BURST_EN
                is_read <= i_rx_byte[7];
`endif
            end
            if (accept_data)
                o_data_out <= i_rx_byte;
            if (state == CAPTURE) begin
                o_tx_byte  <= mod_valid ? data_sel : 8'h00;
                o_tx_valid <= 1'b1;
            end
`ifdef IOC_BUS_MASTER_BURST_EN
            if (accept_burst)
                o_ioc <= o_ioc + 5'd1;
`endif
        end
    end

endmodule
